// File: rtl/hazard_pkg.sv
// Shared types and encodings for the pipeline hazard/forwarding controller.
package hazard_pkg;

  // Widest register address a tracker entry can hold; narrower addresses are zero-extended.
  localparam int unsigned RD_MAX_W = 8;

  // Forwarding select value meaning "take the operand from the register file".
  localparam int unsigned FWD_RF = 0;

  // One in-flight instruction between EX and WB.
  typedef struct packed {
    logic                valid;
    logic [RD_MAX_W-1:0] rd;
    logic                is_load;
  } trk_entry_t;

  // Width of a forwarding select: register file plus one code per tracked stage.
  function automatic int unsigned sel_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Priority matcher: finds the youngest tracked producer of one source register.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH  = 3,
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  trk_entry_t        trk [DEPTH],
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  output logic [SEL_W-1:0]  sel,
  output logic              nofwd
);

  logic hit;

  // Scan from EX (youngest) towards WB and stop at the first valid producer.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    sel   = SEL_W'(FWD_RF);
    nofwd = 1'b0;
    // NOTE: blocking assignments here: 'hit' must be visible to later loop iterations.
    hit   = 1'b0;
    if (used && (src != '0)) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit && trk[k].valid && (trk[k].rd == RD_MAX_W'(src))) begin
          hit   = 1'b1;
          sel   = SEL_W'(k + 1);
          // A load in EX has no data yet; from MEM onward it can be forwarded.
          nofwd = trk[k].is_load && (k == 0);
        end
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: tracks in-flight destinations from EX to WB,
// selects forwarding sources, stalls decode on load-use and squashes on taken branches.
module pipe_hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int DEPTH    = 3,
  parameter int BR_STAGE = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = sel_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wr,
  input  logic              id_load,
  input  logic              br_taken,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_rs1_sel,
  output logic [SEL_W-1:0]  fwd_rs2_sel,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  trk_entry_t trk     [DEPTH];
  trk_entry_t trk_nxt [DEPTH];
  logic       rs1_nofwd;
  logic       rs2_nofwd;
  logic       insert;

  hazard_match #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW),
    .SEL_W  (SEL_W)
  ) u_match_rs1 (
    .trk   (trk),
    .src   (id_rs1),
    .used  (id_rs1_used),
    .sel   (fwd_rs1_sel),
    .nofwd (rs1_nofwd)
  );

  hazard_match #(
    .DEPTH  (DEPTH),
    .REG_AW (REG_AW),
    .SEL_W  (SEL_W)
  ) u_match_rs2 (
    .trk   (trk),
    .src   (id_rs2),
    .used  (id_rs2_used),
    .sel   (fwd_rs2_sel),
    .nofwd (rs2_nofwd)
  );

  // A squashed decode instruction never stalls; only real load-use pairs do.
  assign stall  = id_valid & ~br_taken & (rs1_nofwd | rs2_nofwd);
  // Writes to r0 are dropped so they can never shadow a real producer.
  assign insert = id_valid & id_wr & (id_rd != '0) & ~stall & ~br_taken;

  // Next tracker contents: shift towards WB, clearing everything younger than the branch.
  always_comb begin
    trk_nxt[0] = '0;
    if (insert) begin
      trk_nxt[0] = '{valid: 1'b1, rd: RD_MAX_W'(id_rd), is_load: id_load};
    end
    for (int k = 1; k < DEPTH; k++) begin
      trk_nxt[k] = trk[k-1];
      if (br_taken && (k <= BR_STAGE)) begin
        trk_nxt[k].valid = 1'b0;
      end
    end
  end

  // Tracker register; reset clears every entry so nothing in flight survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the tracker is reset in full because its valid bits gate forwarding and stalls.
      for (int k = 0; k < DEPTH; k++) begin
        trk[k] <= '0;
      end
    end else begin
      // NOTE: non-blocking so every entry shifts from the pre-edge values.
      trk <= trk_nxt;
    end
  end

  // Saturating stall and flush event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (br_taken && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: directed scenarios then random traffic,
// compared against a queue-based model of the in-flight instruction window.
module tb_pipe_hazard_unit;

  localparam int REG_AW   = 5;
  localparam int DEPTH    = 3;
  localparam int BR_STAGE = 1;
  localparam int CNT_W    = 2;
  localparam int SEL_W    = $clog2(DEPTH + 1);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              id_valid, id_rs1_used, id_rs2_used, id_wr, id_load, br_taken;
  logic [REG_AW-1:0] id_rs1, id_rs2, id_rd;
  logic              stall;
  logic [SEL_W-1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_hazard_unit #(
    .REG_AW   (REG_AW),
    .DEPTH    (DEPTH),
    .BR_STAGE (BR_STAGE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .id_rd       (id_rd),
    .id_wr       (id_wr),
    .id_load     (id_load),
    .br_taken    (br_taken),
    .stall       (stall),
    .fwd_rs1_sel (fwd_rs1_sel),
    .fwd_rs2_sel (fwd_rs2_sel),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // mq[0] is the instruction now in EX, mq[DEPTH-1] the one in WB.
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } ment_t;

  ment_t mq[$];
  int    m_stall_cnt;
  int    m_flush_cnt;

  task automatic model_reset();
    ment_t e;
    e = '{v: 1'b0, rd: 0, ld: 1'b0};
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back(e);
    m_stall_cnt = 0;
    m_flush_cnt = 0;
  endtask

  function automatic int m_sel(int src, bit used);
    if (!used || src == 0) return 0;
    for (int k = 0; k < DEPTH; k++) begin
      if (mq[k].v && mq[k].rd == src) return k + 1;
    end
    return 0;
  endfunction

  function automatic bit m_stall();
    bit nf1, nf2;
    nf1 = (m_sel(int'(id_rs1), id_rs1_used) == 1) && mq[0].ld;
    nf2 = (m_sel(int'(id_rs2), id_rs2_used) == 1) && mq[0].ld;
    return id_valid && !br_taken && (nf1 || nf2);
  endfunction

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_clock();
    bit    st, ins;
    ment_t e;
    if (!rst) begin
      model_reset();
    end else begin
      st  = m_stall();
      ins = id_valid && id_wr && (id_rd != 0) && !st && !br_taken;
      if (st && m_stall_cnt < CNT_MAX) m_stall_cnt++;
      if (br_taken && m_flush_cnt < CNT_MAX) m_flush_cnt++;
      if (br_taken) begin
        for (int k = 0; k < BR_STAGE; k++) mq[k].v = 1'b0;
      end
      e = ins ? '{v: 1'b1, rd: int'(id_rd), ld: id_load} : '{v: 1'b0, rd: 0, ld: 1'b0};
      mq.push_front(e);
      void'(mq.pop_back());
    end
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare_model(string tag);
    check({tag, "_stall"},     32'(stall),       32'(m_stall()));
    check({tag, "_sel1"},      32'(fwd_rs1_sel), 32'(m_sel(int'(id_rs1), id_rs1_used)));
    check({tag, "_sel2"},      32'(fwd_rs2_sel), 32'(m_sel(int'(id_rs2), id_rs2_used)));
    check({tag, "_stall_cnt"}, 32'(stall_cnt),   32'(m_stall_cnt));
    check({tag, "_flush_cnt"}, 32'(flush_cnt),   32'(m_flush_cnt));
  endtask

  // Entered 1 ns after a rising edge; compares mid-cycle, then crosses the next edge.
  task automatic step(string tag);
    #1;
    compare_model(tag);
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic set_id(bit v, int r1, bit u1, int r2, bit u2, int rd, bit wr, bit ld, bit br);
    id_valid    = v;
    id_rs1      = r1[REG_AW-1:0];
    id_rs1_used = u1;
    id_rs2      = r2[REG_AW-1:0];
    id_rs2_used = u2;
    id_rd       = rd[REG_AW-1:0];
    id_wr       = wr;
    id_load     = ld;
    br_taken    = br;
  endtask

  task automatic idle();
    set_id(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    idle();
    model_reset();

    // Reset held with a would-be hazard on the ID inputs: everything stays zero.
    set_id(1'b1, 3, 1'b1, 3, 1'b1, 4, 1'b1, 1'b0, 1'b0);
    #3;
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_sel1",  32'(fwd_rs1_sel), 32'd0);
    check("rst_sel2",  32'(fwd_rs2_sel), 32'd0);
    check("rst_cnts",  32'({stall_cnt, flush_cnt}), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    idle();
    rst = 1'b1;
    step("post_rst");

    // ALU chain: add r3 ; add r4,r3,r3 ; add r5,r3,r0
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b0);
    step("alu_add3");
    set_id(1'b1, 3, 1'b1, 3, 1'b1, 4, 1'b1, 1'b0, 1'b0);
    #1;
    check("alu2_sel1", 32'(fwd_rs1_sel), 32'd1);
    check("alu2_sel2", 32'(fwd_rs2_sel), 32'd1);
    step("alu_add4");
    set_id(1'b1, 3, 1'b1, 0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    #1;
    check("alu3_sel1", 32'(fwd_rs1_sel), 32'd2);
    check("alu3_sel2", 32'(fwd_rs2_sel), 32'd0);
    check("alu3_stall", 32'(stall), 32'd0);
    step("alu_add5");

    // Load-use: lw r5 ; add r6,r5 -> one stall, then forward from MEM.
    set_id(1'b1, 1, 1'b1, 0, 1'b0, 5, 1'b1, 1'b1, 1'b0);
    step("lu_load");
    set_id(1'b1, 5, 1'b1, 1, 1'b1, 6, 1'b1, 1'b0, 1'b0);
    #1;
    check("lu_stall_on", 32'(stall), 32'd1);
    check("lu_sel_ex",   32'(fwd_rs1_sel), 32'd1);
    step("lu_stallcyc");
    #1;
    check("lu_stall_off", 32'(stall), 32'd0);
    check("lu_sel_mem",   32'(fwd_rs1_sel), 32'd2);
    check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
    step("lu_use");

    // Zero register: add r0 ; add r1,r0
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    step("zr_wr0");
    set_id(1'b1, 0, 1'b1, 0, 1'b1, 1, 1'b1, 1'b0, 1'b0);
    #1;
    check("zr_sel1",  32'(fwd_rs1_sel), 32'd0);
    check("zr_stall", 32'(stall), 32'd0);
    step("zr_rd0");

    // Youngest wins: r2 written at indices 2 and 0, then read.
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    step("yw_old");
    idle();
    step("yw_nop");
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 2, 1'b1, 1'b0, 1'b0);
    step("yw_new");
    set_id(1'b1, 0, 1'b0, 2, 1'b1, 8, 1'b1, 1'b0, 1'b0);
    #1;
    check("yw_sel2", 32'(fwd_rs2_sel), 32'd1);
    step("yw_read");

    // Branch squashes a load in EX and the reader in ID.
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1, 1'b1, 1'b0);
    step("br_load");
    set_id(1'b1, 7, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0, 1'b1);
    #1;
    check("br_nostall", 32'(stall), 32'd0);
    check("br_sel_ex",  32'(fwd_rs1_sel), 32'd1);
    step("br_take");
    set_id(1'b1, 7, 1'b1, 0, 1'b0, 9, 1'b1, 1'b0, 1'b0);
    #1;
    check("br_squashed", 32'(fwd_rs1_sel), 32'd0);
    check("br_flush1",   32'(flush_cnt), 32'd1);
    step("br_after");
    set_id(1'b1, 1, 1'b1, 2, 1'b1, 3, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("br_multi");
    #1;
    check("br_flush_sat", 32'(flush_cnt), 32'd3);
    idle();
    step("br_idle");

    // Reset mid-operation with a load-use pending.
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1, 1'b1, 1'b0);
    step("mr_load");
    set_id(1'b1, 9, 1'b1, 9, 1'b1, 10, 1'b1, 1'b0, 1'b0);
    #1;
    check("mr_pre_stall", 32'(stall), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("mr_stall", 32'(stall), 32'd0);
    check("mr_sel1",  32'(fwd_rs1_sel), 32'd0);
    check("mr_sel2",  32'(fwd_rs2_sel), 32'd0);
    check("mr_cnts",  32'({stall_cnt, flush_cnt}), 32'd0);
    model_reset();
    @(posedge clk);
    #4;
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_clock();
    #1;
    set_id(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1, 1'b0, 1'b0);
    step("mr_add3");
    set_id(1'b1, 3, 1'b1, 0, 1'b0, 4, 1'b1, 1'b0, 1'b0);
    #1;
    check("mr_fwd", 32'(fwd_rs1_sel), 32'd1);
    step("mr_read3");

    // Random traffic over a small register window to provoke frequent hazards.
    for (int i = 0; i < 400; i++) begin
      set_id(($urandom % 4) != 0,
             int'($urandom_range(0, 7)), ($urandom % 4) != 0,
             int'($urandom_range(0, 7)), ($urandom % 4) != 0,
             int'($urandom_range(0, 7)), ($urandom % 4) != 0,
             ($urandom % 3) == 0,
             ($urandom % 8) == 0);
      step("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the pipelined CPU. It sits beside the decode stage and tracks the destination register of every in-flight instruction between EX and WB. It drives forwarding-mux selects for both source operands and a decode stall on load-use hazards, and it squashes tracked entries on a taken branch. It replaces the fixed add-only datapath's hazard-free assumption and keeps saturating stall/flush performance counters.

## Interface
Parameters:
- REG_AW, 5: register-address width; register 0 is hard-wired zero.
- DEPTH, 3: tracked stages after decode. Index 0 = EX, DEPTH-1 = WB.
- BR_STAGE, 1: tracker index where branches resolve (MEM). Range 1..DEPTH-1.
- CNT_W, 16: performance-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1, id_rs2  in  REG_AW  source register addresses.
- id_rs1_used, id_rs2_used  in  1  the source is actually read.
- id_rd  in  REG_AW  destination register.
- id_wr  in  1  instruction writes id_rd.
- id_load  in  1  instruction is a load (result available from MEM onward).
- br_taken  in  1  the branch at tracker index BR_STAGE is taken this cycle.
- stall  out  1  hold PC and IF/ID, inject a bubble into EX.
- fwd_rs1_sel, fwd_rs2_sel  out  SEL_W = $clog2(DEPTH+1)  operand source: 0 = register file, k+1 = result of tracker index k.
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters.

## Operation
- Tracker state: trk[0..DEPTH-1], each entry holding {valid, rd, is_load}.
- Per-source match, evaluated combinationally from the tracker and ID inputs:
  - Ignore the source if it is not used or its address is 0.
  - Scan indices 0 to DEPTH-1 and take the first (youngest) entry with valid and rd equal to the source.
  - No match: sel = 0.
  - Match at index k: sel = k+1. The entry is non-forwardable when is_load=1 and k=0.
- stall = id_valid & !br_taken & (rs1 non-forwardable | rs2 non-forwardable).
- While stalled, sel outputs still show the computed match; decode ignores them.
- Tracker shift on each clock edge: trk[k] <= trk[k-1] for k ≥ 1.
- New entry at trk[0]:
  - A valid entry {1, id_rd, id_load} is inserted only when id_valid & id_wr & id_rd≠0 & !stall & !br_taken.
  - Otherwise trk[0] receives a bubble (valid=0).
- Taken branch (br_taken=1):
  - Every entry with index < BR_STAGE is invalidated as it shifts, so it arrives at index ≤ BR_STAGE as invalid.
  - The decode instruction is not inserted.
  - The branch entry itself and all older entries shift normally.
- br_taken overrides stall: the squashed instruction never stalls.
- Counters:
  - stall_cnt increments on every cycle with stall=1.
  - flush_cnt increments on every cycle with br_taken=1.
  - Both saturate at 2^CNT_W-1.
- WB-to-ID hazard: forwarding from index DEPTH-1 covers the register-file write/read in the same cycle. The register file needs no write-first behaviour.

## Timing
- Reset (rst=0, asynchronous):
  - All trk valid=0, counters 0.
  - Therefore stall=0 and both sels=0 while reset is held and on the first cycle after release.
- stall and sels are combinational: zero cycles from ID inputs, one cycle from tracker updates.
- A load-use pair costs exactly one stall cycle. In the following cycle the load sits at index 1 and sel=2.
- Reset asserted mid-operation discards all in-flight tracking immediately. No partial flush state survives.
- br_taken is sampled only on the edge at which it is asserted. A multi-cycle assertion flushes on each such cycle and counts each one.

## Structure
- hazard_pkg:
  - trk_entry_t struct {valid, rd, is_load}.
  - FWD_RF = 0 select encoding.
  - Helper function for SEL_W.
- Sub-module hazard_match: a priority matcher over the tracker for one source. It outputs sel and nofwd and is instantiated twice (rs1, rs2).
- The top holds the tracker shift register, the stall/insert logic and the counters.

## Test plan
- Reset: run traffic, pull rst=0 mid-cycle → all outputs 0 immediately. After release, add r3 then read r3 → sel=1.
- ALU chain: add r3; add r4,r3,r3; add r5,r3,r0 → rs1 and rs2 sel=1 for the second instruction; rs1 sel=2 for the third; stall=0 throughout.
- Load-use: lw r5; add r6,r5 → stall=1 for one cycle, trk[0] bubble, then sel=2, stall_cnt=1.
- Zero register: add r0; add r1,r0 → sel=0, stall=0, no entry inserted.
- Youngest wins: writes to r2 at indices 0 and 2, read r2 → sel=1.
- Branch: set br_taken with a load r7 at index 0 and ID reading r7 → stall=0. Next cycle no r7 entry is left at or below BR_STAGE, and flush_cnt=1. With CNT_W=2, four flushes → flush_cnt stays 3.
